run_controller: RTL and testbench

Hardware sequencer that sits directly upstream of the singlecycle core. It drives the core's resetl and startpc and watches currentpc and dmemout to decide when a program has finished. It then captures the pass code and compares it with an expected value, with a watchdog that catches runaway programs. It lets several programs run back-to-back on the core without a testbench driving the core's reset.

---
 rtl/run_controller.sv | 124 ++++++++++++
 tb/tb_run_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run sequencer for the single-cycle core: holds the core in reset, releases it at
// start_pc, waits for the end PC, then captures and judges the pass code with a watchdog.
module run_controller #(
   parameter int RESET_CYCLES  = 1,
   parameter int CAPTURE_DELAY = 1,
   parameter int WATCHDOG_MAX  = 255,
   parameter int CNT_W         = 16
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [63:0]      start_pc,
   input  logic [63:0]      end_pc,
   input  logic [63:0]      expected,
   input  logic [63:0]      core_currentpc,
   input  logic [63:0]      core_dmemout,
   output logic             core_resetl,
   output logic [63:0]      core_startpc,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [63:0]      result,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int HOLD_W   = $clog2(RESET_CYCLES + 1);
   localparam int SETTLE_W = $clog2(CAPTURE_DELAY + 1);
   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(WATCHDOG_MAX);

   typedef enum logic [2:0] {IDLE, HOLD_RESET, RUN, SETTLE, DONE} state_t;

   state_t              state;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [63:0]         end_pc_q;
   logic [63:0]         expected_q;

   // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         hold_cnt     <= '0;
         settle_cnt   <= '0;
         end_pc_q     <= '0;
         expected_q   <= '0;
         core_resetl  <= 1'b0;
         core_startpc <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         timeout      <= 1'b0;
         result       <= '0;
         cycle_count  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               // A new run may be launched from DONE without passing through IDLE.
               if (start) begin
                  end_pc_q     <= end_pc;
                  expected_q   <= expected;
                  core_startpc <= start_pc;
                  done         <= 1'b0;
                  pass         <= 1'b0;
                  timeout      <= 1'b0;
                  result       <= '0;
                  cycle_count  <= '0;
                  core_resetl  <= 1'b0;
                  hold_cnt     <= HOLD_W'(RESET_CYCLES);
                  busy         <= 1'b1;
                  state        <= HOLD_RESET;
               end else begin
                  core_resetl <= 1'b1;
               end
            end

            HOLD_RESET: begin
               if (hold_cnt == HOLD_W'(1)) begin
                  core_resetl <= 1'b1;
                  cycle_count <= '0;
                  state       <= RUN;
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end

            RUN: begin
               // End test wins over the watchdog when both hit on the same cycle.
               if (core_currentpc >= end_pc_q) begin
                  cycle_count <= cycle_count + 1'b1;
                  settle_cnt  <= SETTLE_W'(CAPTURE_DELAY);
                  state       <= SETTLE;
               end else if ((cycle_count + 1'b1) == WD_LIMIT) begin
                  cycle_count <= WD_LIMIT;
                  timeout     <= 1'b1;
                  pass        <= 1'b0;
                  result      <= '0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= DONE;
               end else begin
                  cycle_count <= cycle_count + 1'b1;
               end
            end

            SETTLE: begin
               cycle_count <= cycle_count + 1'b1;
               if (settle_cnt == SETTLE_W'(1)) begin
                  result <= core_dmemout;
                  pass   <= (core_dmemout == expected_q);
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= DONE;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: a stepping-PC core model, a scoreboard of expected
// run outcomes pushed at launch and popped when done rises, plus reset and hold checks.
module tb_run_controller;

   localparam int RESET_CYCLES  = 1;
   localparam int CAPTURE_DELAY = 1;
   localparam int WATCHDOG_MAX  = 255;
   localparam int CNT_W         = 16;

   logic             CLK = 1'b0;
   logic             reset;
   logic             start;
   logic [63:0]      start_pc, end_pc, expected;
   logic [63:0]      core_currentpc;
   logic [63:0]      core_dmemout;
   logic             core_resetl;
   logic [63:0]      core_startpc;
   logic             busy, done, pass, timeout;
   logic [63:0]      result;
   logic [CNT_W-1:0] cycle_count;

   typedef struct {
      logic        pass;
      logic        timeout;
      logic [63:0] result;
      logic [63:0] count;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;

   always #5 CLK = ~CLK;

   run_controller #(
      .RESET_CYCLES (RESET_CYCLES),
      .CAPTURE_DELAY(CAPTURE_DELAY),
      .WATCHDOG_MAX (WATCHDOG_MAX),
      .CNT_W        (CNT_W)
   ) dut (
      .CLK           (CLK),
      .reset         (reset),
      .start         (start),
      .start_pc      (start_pc),
      .end_pc        (end_pc),
      .expected      (expected),
      .core_currentpc(core_currentpc),
      .core_dmemout  (core_dmemout),
      .core_resetl   (core_resetl),
      .core_startpc  (core_startpc),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .timeout       (timeout),
      .result        (result),
      .cycle_count   (cycle_count)
   );

   // Core stand-in: PC reloads from startpc while held in reset, otherwise steps by 4.
   always @(posedge CLK) begin
      if (!core_resetl) core_currentpc <= core_startpc;
      else              core_currentpc <= core_currentpc + 64'd4;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic exp_t model(input logic [63:0] s, input logic [63:0] e,
                                  input logic [63:0] x, input logic [63:0] d);
      exp_t m;
      longint unsigned c_end;
      c_end = (e <= s) ? 0 : (e - s + 64'd3) / 64'd4;
      if (c_end >= longint'(WATCHDOG_MAX)) begin
         m.pass = 1'b0; m.timeout = 1'b1; m.result = '0; m.count = 64'(WATCHDOG_MAX);
      end else begin
         m.pass = (d == x); m.timeout = 1'b0; m.result = d;
         m.count = c_end + 64'd1 + 64'(CAPTURE_DELAY);
      end
      return m;
   endfunction

   task automatic launch(input logic [63:0] s, input logic [63:0] e, input logic [63:0] x,
                         input logic [63:0] d, input bit push, input bit check_hold);
      int n;
      start_pc = s; end_pc = e; expected = x; core_dmemout = d; start = 1'b1;
      if (push) sb.push_back(model(s, e, x, d));
      @(negedge CLK);
      start = 1'b0;
      check("launch.startpc", core_startpc, s);
      check("launch.busy", 64'(busy), 64'd1);
      if (check_hold) begin
         n = 0;
         while (!core_resetl && n < 20) begin
            n++;
            @(negedge CLK);
         end
         check("hold.cycles", 64'(n), 64'(RESET_CYCLES));
      end
   endtask

   task automatic finish_run(input string tag);
      exp_t e;
      int   n = 0;
      while (!done && n < 2000) begin
         n++;
         @(negedge CLK);
      end
      check({tag, ".done"}, 64'(done), 64'd1);
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      check({tag, ".pass"},    64'(pass),        64'(e.pass));
      check({tag, ".timeout"}, 64'(timeout),     64'(e.timeout));
      check({tag, ".result"},  result,           e.result);
      check({tag, ".count"},   64'(cycle_count), e.count);
      check({tag, ".busy"},    64'(busy),        64'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      start_pc = '0; end_pc = '0; expected = '0; core_dmemout = '0;
      #1;
      check("rst.resetl",  64'(core_resetl), 64'd0);
      check("rst.startpc", core_startpc,     64'd0);
      check("rst.busy",    64'(busy),        64'd0);
      check("rst.done",    64'(done),        64'd0);
      check("rst.result",  result,           64'd0);
      check("rst.count",   64'(cycle_count), 64'd0);
      @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
      check("idle.resetl", 64'(core_resetl), 64'd1);

      // Nominal run.
      launch(64'h0, 64'h34, 64'hF, 64'hF, 1'b1, 1'b1);
      finish_run("nominal");

      // Mismatched pass code, with a start pulse during RUN that must be ignored.
      launch(64'h0, 64'h34, 64'hF, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
      repeat (3) @(negedge CLK);
      start_pc = 64'h999; end_pc = 64'h0; expected = 64'h1234_5678_9ABC_DEF0; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      check("busy_start.startpc", core_startpc, 64'h0);
      check("busy_start.busy", 64'(busy), 64'd1);
      finish_run("mismatch");

      // Watchdog.
      launch(64'h0, 64'h1000, 64'hF, 64'hF, 1'b1, 1'b0);
      finish_run("watchdog");

      // Back-to-back: second run launched straight from DONE.
      launch(64'h0, 64'h34, 64'hF, 64'hF, 1'b1, 1'b0);
      finish_run("b2b_first");
      launch(64'h38, 64'h5C, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
      finish_run("b2b_second");

      // Immediate end: end_pc equals start_pc.
      launch(64'h40, 64'h40, 64'h7, 64'h7, 1'b1, 1'b0);
      finish_run("immediate");

      // Async reset mid-RUN, applied between clock edges.
      launch(64'h0, 64'h1000, 64'hF, 64'hF, 1'b0, 1'b0);
      repeat (4) @(negedge CLK);
      @(posedge CLK);
      #2 reset = 1'b1;
      #1;
      check("areset.resetl", 64'(core_resetl), 64'd0);
      check("areset.busy",   64'(busy),        64'd0);
      check("areset.done",   64'(done),        64'd0);
      check("areset.count",  64'(cycle_count), 64'd0);
      @(negedge CLK);
      reset = 1'b0;
      @(posedge CLK);
      #1;
      check("release.resetl", 64'(core_resetl), 64'd1);
      check("release.busy",   64'(busy),        64'd0);
      check("release.done",   64'(done),        64'd0);
      check("sb.drained",     64'(sb.size()),   64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
